// File: rtl/text_pkg.sv
// Shared constants, types and address packing for the VGA text-buffer writer.
// The display read side uses the same {col,row} address layout.
package text_pkg;

    localparam int COLS   = 64;
    localparam int ROWS   = 30;
    localparam int COL_W  = 6;
    localparam int ROW_W  = 5;
    localparam int ADDR_W = COL_W + ROW_W;
    localparam int CELLS  = COLS * ROWS;
    localparam int CNT_W  = $clog2(CELLS + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    localparam logic [6:0] BLANK    = 7'h20;
    localparam logic [6:0] CH_TILDE = 7'h7E;
    localparam logic [6:0] CH_CR    = 7'h0D;
    localparam logic [6:0] CH_LF    = 7'h0A;
    localparam logic [6:0] CH_BS    = 7'h08;
    localparam logic [6:0] CH_FF    = 7'h0C;

    typedef enum logic { CLEAR, IDLE } state_t;

    typedef enum logic [2:0] {
        CUR_HOLD,
        CUR_ADVANCE,
        CUR_RETREAT,
        CUR_NEWLINE,
        CUR_HOME
    } cursor_cmd_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [COL_W-1:0] col,
                                                    input logic [ROW_W-1:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Text cursor register with advance/retreat/newline/home and screen wrap.
// Also exposes the retreat target so a backspace can write where the cursor lands.
module text_cursor
    import text_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  cursor_cmd_t      cmd,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] back_col,
    output logic [ROW_W-1:0] back_row,
    output logic             at_home
);

    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_d;
    logic [ROW_W-1:0] row_up;

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
        col_d    = col;
        row_d    = row;
        row_up   = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        back_col = (col == '0) ? COL_LAST : col - COL_W'(1);
        back_row = (col == '0) ? row - ROW_W'(1) : row;
        at_home  = (col == '0) && (row == '0);

        case (cmd)
            CUR_ADVANCE: begin
                if (col == COL_LAST) begin
                    col_d = '0;
                    row_d = row_up;
                end else begin
                    col_d = col + COL_W'(1);
                end
            end
            CUR_RETREAT: begin
                if (!at_home) begin
                    col_d = back_col;
                    row_d = back_row;
                end
            end
            CUR_NEWLINE: begin
                col_d = '0;
                row_d = row_up;
            end
            CUR_HOME: begin
                col_d = '0;
                row_d = '0;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= col_d;
            row <= row_d;
        end
    end

endmodule

// File: rtl/text_buffer_writer.sv
// Feeds the VGA text RAM from a valid/ready ASCII stream, clearing the screen after
// reset and on form-feed; the clear scan reuses the cursor's advance path.
module text_buffer_writer
    import text_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [6:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [6:0]        ram_write_data,
    output logic              ram_we,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row
);

    state_t            state, state_d;
    logic [CNT_W-1:0]  clear_cnt, clear_cnt_d;
    logic              ready_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [6:0]        data_d;
    cursor_cmd_t       cmd;
    logic [COL_W-1:0]  back_col;
    logic [ROW_W-1:0]  back_row;
    logic              at_home;

    text_cursor u_cursor (
        .clock    (clock),
        .reset    (reset),
        .cmd      (cmd),
        .col      (cursor_col),
        .row      (cursor_row),
        .back_col (back_col),
        .back_row (back_row),
        .at_home  (at_home)
    );

    always_comb begin
        state_d     = state;
        clear_cnt_d = clear_cnt;
        ready_d     = char_ready;
        we_d        = 1'b0;
        addr_d      = ram_write_addr;
        data_d      = ram_write_data;
        cmd         = CUR_HOLD;

        case (state)
            CLEAR: begin
                ready_d = 1'b0;
                // After CELLS advances the cursor has wrapped back to (0,0) on its own.
                if (clear_cnt == CNT_W'(CELLS)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    we_d        = 1'b1;
                    addr_d      = pack_addr(cursor_col, cursor_row);
                    data_d      = BLANK;
                    cmd         = CUR_ADVANCE;
                    clear_cnt_d = clear_cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                ready_d = 1'b1;
                if (char_valid && char_ready) begin
                    if (char_in >= BLANK && char_in <= CH_TILDE) begin
                        we_d   = 1'b1;
                        addr_d = pack_addr(cursor_col, cursor_row);
                        data_d = char_in;
                        cmd    = CUR_ADVANCE;
                    end else begin
                        case (char_in)
                            CH_CR, CH_LF: cmd = CUR_NEWLINE;
                            CH_BS: begin
                                if (!at_home) begin
                                    we_d   = 1'b1;
                                    addr_d = pack_addr(back_col, back_row);
                                    data_d = BLANK;
                                    cmd    = CUR_RETREAT;
                                end
                            end
                            CH_FF: begin
                                state_d     = CLEAR;
                                clear_cnt_d = '0;
                                ready_d     = 1'b0;
                                cmd         = CUR_HOME;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= CLEAR;
            clear_cnt      <= '0;
            char_ready     <= 1'b0;
            ram_we         <= 1'b0;
            ram_write_addr <= '0;
            ram_write_data <= '0;
        end else begin
            state          <= state_d;
            clear_cnt      <= clear_cnt_d;
            char_ready     <= ready_d;
            ram_we         <= we_d;
            ram_write_addr <= addr_d;
            ram_write_data <= data_d;
        end
    end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Scoreboard bench for text_buffer_writer: a linear-index cursor model queues the
// expected RAM writes and a negedge monitor pops and compares each observed write.
module tb_text_buffer_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  char_in = '0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [10:0] ram_write_addr;
    logic [6:0]  ram_write_data;
    logic        ram_we;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;

    text_buffer_writer dut (
        .clock          (clock),
        .reset          (reset),
        .char_in        (char_in),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_we         (ram_we),
        .cursor_col     (cursor_col),
        .cursor_row     (cursor_row)
    );

    always #20 clock = ~clock;

    typedef struct packed {
        logic [10:0] addr;
        logic [6:0]  data;
    } wr_t;

    wr_t         sb[$];
    wr_t         mon_exp;
    int          vectors = 0;
    int          miscompares = 0;
    int          model_pos = 0;     // row*64 + col
    int          writes_seen = 0;
    logic [10:0] last_addr = '0;
    logic [6:0]  last_data = '0;

    function automatic logic [10:0] addr_of(input int pos);
        logic [5:0] c;
        logic [4:0] r;
        c = 6'(pos % 64);
        r = 5'(pos / 64);
        return {c, r};
    endfunction

    function automatic logic [10:0] model_cursor();
        return addr_of(model_pos);
    endfunction

    task automatic push_write(input int pos, input logic [6:0] d);
        wr_t w;
        w.addr = addr_of(pos);
        w.data = d;
        sb.push_back(w);
    endtask

    task automatic push_clear();
        for (int k = 0; k < 1920; k++) push_write(k, 7'h20);
    endtask

    always @(negedge clock) begin
        if (!reset && ram_we === 1'b1) begin
            writes_seen++;
            last_addr = ram_write_addr;
            last_data = ram_write_data;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                         ram_write_addr, ram_write_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({ram_write_addr, ram_write_data} !== {mon_exp.addr, mon_exp.data}) begin
                    miscompares++;
                    $display("FAIL ram_write: got addr=%h data=%h, expected addr=%h data=%h",
                             ram_write_addr, ram_write_data, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (char_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: char_ready=%b after %0d cycles, expected 1", char_ready, n);
        end
    endtask

    task automatic send(input logic [6:0] ch);
        logic exp_we = 1'b0;
        logic exp_ff = 1'b0;
        wait_ready();
        char_in    = ch;
        char_valid = 1'b1;
        if (ch >= 7'h20 && ch <= 7'h7E) begin
            push_write(model_pos, ch);
            exp_we    = 1'b1;
            model_pos = (model_pos + 1) % 1920;
        end else if (ch == 7'h0D || ch == 7'h0A) begin
            model_pos = ((model_pos / 64 + 1) % 30) * 64;
        end else if (ch == 7'h08) begin
            if (model_pos != 0) begin
                model_pos = model_pos - 1;
                push_write(model_pos, 7'h20);
                exp_we = 1'b1;
            end
        end else if (ch == 7'h0C) begin
            model_pos = 0;
            exp_ff    = 1'b1;
        end
        tick();
        char_valid = 1'b0;
        vectors++;
        if (ram_we !== exp_we) begin
            miscompares++;
            $display("FAIL send_we ch=%h: got ram_we=%b, expected %b", ch, ram_we, exp_we);
        end
        vectors++;
        if ({cursor_col, cursor_row} !== model_cursor()) begin
            miscompares++;
            $display("FAIL send_cursor ch=%h: got col=%0d row=%0d, expected {col,row}=%h",
                     ch, cursor_col, cursor_row, model_cursor());
        end
        vectors++;
        if (char_ready !== !exp_ff) begin
            miscompares++;
            $display("FAIL send_ready ch=%h: got char_ready=%b, expected %b", ch, char_ready, !exp_ff);
        end
        if (exp_ff) push_clear();
    endtask

    // Expects the first blank write on the next edge, 1920 in total, then ready.
    task automatic check_clear();
        int start = writes_seen;
        for (int i = 0; i < 1920; i++) begin
            tick();
            vectors++;
            if (ram_we !== 1'b1 || char_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL clear_cycle %0d: got ram_we=%b char_ready=%b, expected 1 and 0",
                         i, ram_we, char_ready);
            end
            if (i == 0) begin
                vectors++;
                if (ram_write_addr !== 11'h000) begin
                    miscompares++;
                    $display("FAIL clear_first_addr: got %h, expected 000", ram_write_addr);
                end
            end
        end
        tick();
        vectors++;
        if (ram_we !== 1'b0 || char_ready !== 1'b1 || {cursor_col, cursor_row} !== 11'h000) begin
            miscompares++;
            $display("FAIL clear_done: got ram_we=%b char_ready=%b col=%0d row=%0d, expected 0 1 0 0",
                     ram_we, char_ready, cursor_col, cursor_row);
        end
        vectors++;
        if (writes_seen - start !== 1920 || last_addr !== 11'h7FD) begin
            miscompares++;
            $display("FAIL clear_span: got %0d writes last=%h, expected 1920 last=7FD",
                     writes_seen - start, last_addr);
        end
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if ({char_ready, ram_we, ram_write_addr, ram_write_data, cursor_col, cursor_row} !== '0) begin
            miscompares++;
            $display("FAIL %s: got ready=%b we=%b addr=%h data=%h col=%0d row=%0d, expected all 0",
                     tag, char_ready, ram_we, ram_write_addr, ram_write_data, cursor_col, cursor_row);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        check_reset_values("reset_values");
        model_pos = 0;
        push_clear();
        reset = 1'b0;
        check_clear();
    endtask

    task automatic test_print();
        send(7'h41);
        vectors++;
        if (last_addr !== 11'h000 || last_data !== 7'h41) begin
            miscompares++;
            $display("FAIL print_first: got addr=%h data=%h, expected 000 41", last_addr, last_data);
        end
        send(7'h41);
        send(7'h42);
        send(7'h43);
    endtask

    task automatic test_wrap();
        send(7'h0C);
        check_clear();
        for (int i = 0; i < 63; i++) send(7'(97 + i % 26));
        send(7'h5A);
        vectors++;
        if (last_addr !== 11'h7E0 || {cursor_col, cursor_row} !== {6'd0, 5'd1}) begin
            miscompares++;
            $display("FAIL wrap_col: got addr=%h col=%0d row=%0d, expected 7E0 0 1",
                     last_addr, cursor_col, cursor_row);
        end
        send(7'h08);
        vectors++;
        if (last_addr !== 11'h7E0 || last_data !== 7'h20 || {cursor_col, cursor_row} !== {6'd63, 5'd0}) begin
            miscompares++;
            $display("FAIL backspace_row: got addr=%h data=%h col=%0d row=%0d, expected 7E0 20 63 0",
                     last_addr, last_data, cursor_col, cursor_row);
        end
        for (int i = 0; i < 29; i++) send(7'h0D);
        for (int i = 0; i < 63; i++) send(7'h2E);
        send(7'h5A);
        vectors++;
        if (last_addr !== 11'h7FD || {cursor_col, cursor_row} !== 11'h000) begin
            miscompares++;
            $display("FAIL wrap_screen: got addr=%h col=%0d row=%0d, expected 7FD 0 0",
                     last_addr, cursor_col, cursor_row);
        end
        send(7'h08);
    endtask

    task automatic test_controls();
        for (int i = 0; i < 29; i++) send(7'h0A);
        for (int i = 0; i < 5; i++) send(7'h30 + 7'(i));
        vectors++;
        if ({cursor_col, cursor_row} !== {6'd5, 5'd29}) begin
            miscompares++;
            $display("FAIL reach_5_29: got col=%0d row=%0d, expected 5 29", cursor_col, cursor_row);
        end
        send(7'h0D);
        send(7'h31);
        send(7'h07);
        send(7'h7F);
        send(7'h1B);
        send(7'h7E);
    endtask

    task automatic test_reset_midclear();
        send(7'h0C);
        for (int i = 0; i < 500; i++) begin
            tick();
            vectors++;
            if (ram_we !== 1'b1) begin
                miscompares++;
                $display("FAIL midclear_pre %0d: got ram_we=%b, expected 1", i, ram_we);
            end
        end
        reset = 1'b1;
        sb.delete();
        tick();
        check_reset_values("midclear_reset");
        tick();
        model_pos = 0;
        push_clear();
        reset = 1'b0;
        check_clear();
        send(7'h48);
    endtask

    initial begin
        test_reset();
        test_print();
        test_wrap();
        test_controls();
        test_reset_midclear();
        tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending writes, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
